seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage of the stopwatch: takes the four BCD digits from the counter core
//  and time-multiplexes them onto the shared 4-anode / 8-segment display (an, seg).
//  Snapshots each digit at its slot start, inserts an anti-ghosting guard gap between digits,
//  and produces registered, glitch-free active-low drive.
// PARAMETERS
//  REFRESH_DIV  50000  cycles per digit slot (50 MHz mclk -> 1 kHz slot, 250 Hz frame); must be >= GUARD+2
//  GUARD        16     cycles at the start of each slot with all anodes off (ghosting guard); >= 1
// PORTS
//  mclk    in   1   system clock; all state on rising edge
//  clear   in   1   asynchronous, active-low reset
//  digits  in   16  {d3,d2,d1,d0} nibbles, d3 = leftmost; values A-F are legal
//  dp      in   4   decimal point request per digit, dp[i] lights digit i's point
//  blank   in   1   synchronous display blank, active-high
//  an      out  4   anode enables, active-low, an[i] = digit i
//  seg     out  8   active-low segments: seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp
// BEHAVIOUR
//  - Reset (clear=0, async): an=4'b1111, seg=8'hFF, slot counter=0, idx=0, snapshot=0.
//  - Slot counter cnt runs 0..REFRESH_DIV-1, then wraps to 0.
//    On wrap: idx <= idx+1 mod 4, with 3->0 (order d0,d1,d2,d3).
//  - Snapshot: at cnt==0 the block latches digits[4*idx+:4] and dp[idx] into a holding register.
//    Input changes mid-slot never alter the displayed digit until the next slot.
//  - Guard: for cnt < GUARD, an=4'b1111 and seg=8'hFF.
//  - Drive: for GUARD <= cnt < REFRESH_DIV, an has only bit idx low.
//    seg = decode(snapshot value) with seg[7] = ~snapshot dp.
//  - Latency: outputs are registered, so an/seg reflect cnt/idx one cycle later.
//    First lit digit appears GUARD+1 cycles after clear rises.
//  - Decode (active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90
//                         A=88 b=83 C=C6 d=A1 E=86 F=8E  (dp bit high, i.e. off)
//  - Enabled digits never have two anodes low in the same cycle. an never takes a value other than
//    1111 or a single 0 bit.
//  - blank=1: an=1111 and seg=FF from the next cycle. cnt and idx keep running, so the scan phase is
//    preserved. On deassert, the display resumes mid-slot with the current idx and its snapshot.
//  - Simultaneous blank and slot wrap: the wrap happens and blank wins on the outputs.
//  - clear asserted mid-slot: outputs go to reset values immediately and the scan restarts at d0.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Digit i (i = 3..1) is suppressed when its nibble and all higher nibbles are 0, evaluated on the
//      slot snapshot.
//    - A suppressed digit keeps an=1111 and seg=FF for its whole slot, including its dp.
//    - d0 is never suppressed.
//  LEADING_ZERO_BLANK_EN undefined: all four digits are always lit (outside guard/blank).
// TESTING (bench: REFRESH_DIV=8, GUARD=2)
//  1 Reset: clear=0 -> an=1111, seg=FF. Release clear -> an=1111 for 3 cycles, then an=1110.
//  2 Scan: digits=16'h1234, dp=0. Over one frame, lit slots show
//      an=1110 with seg=99, an=1101 with seg=B0, an=1011 with seg=A4, an=0111 with seg=F9.
//    Each lit phase lasts 6 cycles and is followed by a 2-cycle an=1111 guard.
//  3 Decimal point: dp=4'b0100, digits=16'h0000 -> seg=40 only while an=1011.
//    seg=C0 in all other lit slots.
//  4 Snapshot: change digits from 16'h1234 to 16'h5678 at cnt=4 of the d0 slot.
//    d0 keeps seg=99 to the end of the slot; the next d1 slot shows seg=F8 (7).
//  5 Leading-zero: digits=16'h0050.
//    With LEADING_ZERO_BLANK_EN: an[3] and an[2] never go low; d1 shows 92, d0 shows C0.
//    Without the macro: all four anodes cycle, with d3/d2 showing C0.
//  6 blank/clear mid-slot: blank=1 at cnt=5 -> an=1111 next cycle; release -> same idx relit.
//    clear=0 at cnt=5 -> an=1111, seg=FF the same cycle; after release the scan restarts at d0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Display stage of the stopwatch. Time-multiplexes four BCD/hex digits onto a
//   shared 4-anode / 8-segment display. Each digit slot is REFRESH_DIV cycles:
//   the first GUARD cycles keep every anode off (anti-ghosting), the rest drive
//   the digit captured at the slot start. All drive is registered, active-low.
//
//   Parameters
//     REFRESH_DIV  cycles per digit slot (>= GUARD+2)
//     GUARD        blanked cycles at the start of each slot (>= 1)
//
//   Ports
//     mclk    in   system clock, rising edge
//     clear   in   asynchronous active-low reset
//     digits  in   {d3,d2,d1,d0} nibbles, d3 leftmost
//     dp      in   decimal point request, dp[i] for digit i
//     blank   in   synchronous display blank, active-high
//     an      out  anode enables, active-low, an[i] = digit i
//     seg     out  segments, active-low: seg[6:0] = g..a, seg[7] = dp
//
//   Build option
//     LEADING_ZERO_BLANK_EN  suppress digits 3..1 when they and every higher
//                            nibble are zero (judged on the slot snapshot)
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned GUARD       = 16
) (
   input  logic        mclk,
   input  logic        clear,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   input  logic        blank,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   localparam int unsigned   CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    snap_val;
   logic          snap_dp;
   logic          snap_sup;
   logic [3:0]    an_nx;
   logic [7:0]    seg_nx;

   // Active-low g..a pattern for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h7F;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Slot counter and digit index; idx advances d0 -> d1 -> d2 -> d3 -> d0.
   always_ff @(posedge mclk or negedge clear) begin
      if (!clear) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Digit and dp are captured once per slot so mid-slot input changes cannot
   // disturb the digit being shown. GUARD >= 1 guarantees the capture lands
   // before the first lit cycle of the slot.
   always_ff @(posedge mclk or negedge clear) begin
      if (!clear) begin
         snap_val <= '0;
         snap_dp  <= 1'b0;
      end else if (cnt == '0) begin
         snap_val <= digits[{idx, 2'b00} +: 4];
         snap_dp  <= dp[idx];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic sup_now;

   always_comb begin
      sup_now = 1'b0;
      case (idx)
         2'd3:    sup_now = (digits[15:12] == 4'h0);
         2'd2:    sup_now = (digits[15:8]  == 8'h00);
         2'd1:    sup_now = (digits[15:4]  == 12'h000);
         default: sup_now = 1'b0;
      endcase
   end

   always_ff @(posedge mclk or negedge clear) begin
      if (!clear) begin
         snap_sup <= 1'b0;
      end else if (cnt == '0) begin
         snap_sup <= sup_now;
      end
   end
`else
   assign snap_sup = 1'b0;
`endif

   // Blank, guard and suppression all force the dark pattern; only one anode
   // can ever be selected because it is derived from the single idx value.
   always_comb begin
      an_nx  = '1;
      seg_nx = '1;
      if (!blank && (cnt >= CNT_GUARD) && !snap_sup) begin
         an_nx  = ~(4'b0001 << idx);
         seg_nx = {~snap_dp, decode(snap_val)};
      end
   end

   always_ff @(posedge mclk or negedge clear) begin
      if (!clear) begin
         an  <= '1;
         seg <= '1;
      end else begin
         an  <= an_nx;
         seg <= seg_nx;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver with REFRESH_DIV=8, GUARD=2. Full frames are
//   driven from a vector table; snapshot, blank and mid-slot clear are
//   hand-written sequences. Expected an/seg come from the cycle position since
//   clear was released and the hand-computed segment table.
module tb_seg7_scan_driver;

   localparam int unsigned RD = 8;
   localparam int unsigned GD = 2;

   logic        mclk;
   logic        clear;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        blank;
   logic [3:0]  an;
   logic [7:0]  seg;

   int unsigned checks;
   int unsigned errors;
   int unsigned pos;
   logic        exp_blank;

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp;
      logic [3:0][7:0] segs;   // {d3,d2,d1,d0} expected segment bytes
      logic [3:0]      lit;    // digits expected to be lit
   } vec_t;

   vec_t vecs[6];

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] LIT_ZERO = 4'b0001;
   localparam logic [3:0] LIT_0050 = 4'b0011;
`else
   localparam logic [3:0] LIT_ZERO = 4'b1111;
   localparam logic [3:0] LIT_0050 = 4'b1111;
`endif

   localparam logic [3:0][7:0] SEG_1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
   localparam logic [3:0][7:0] SEG_5678 = {8'h92, 8'h82, 8'hF8, 8'h80};
   localparam logic [3:0][7:0] SEG_EF89 = {8'h86, 8'h8E, 8'h80, 8'h10};

   seg7_scan_driver #(
      .REFRESH_DIV(RD),
      .GUARD      (GD)
   ) dut (
      .mclk  (mclk),
      .clear (clear),
      .digits(digits),
      .dp    (dp),
      .blank (blank),
      .an    (an),
      .seg   (seg)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s pos=%0d: got %h expected %h", name, pos, act, exp);
      end
   endtask

   // One clock; outputs after edge #pos reflect cnt=(pos-1)%RD, idx=((pos-1)/RD)%4.
   task automatic step(input logic [3:0][7:0] segs, input logic [3:0] lit);
      int unsigned c;
      int unsigned i;
      logic [3:0]  ea;
      logic [7:0]  es;
      @(posedge mclk);
      pos++;
      @(negedge mclk);
      c  = (pos - 1) % RD;
      i  = ((pos - 1) / RD) % 4;
      ea = 4'hF;
      es = 8'hFF;
      if (!exp_blank && c >= GD && lit[i]) begin
         ea = ~(4'b0001 << i);
         es = segs[i];
      end
      check("an", {4'h0, an}, {4'h0, ea});
      check("seg", seg, es);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pos       = 0;
      exp_blank = 1'b0;

      vecs[0] = '{16'h1234, 4'b0000, SEG_1234, 4'hF};
      vecs[1] = '{16'h0000, 4'b0100, {8'hC0, 8'h40, 8'hC0, 8'hC0}, LIT_ZERO};
      vecs[2] = '{16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0}, LIT_0050};
      vecs[3] = '{16'hABCD, 4'b1111, {8'h08, 8'h03, 8'h46, 8'h21}, 4'hF};
      vecs[4] = '{16'hEF89, 4'b0001, SEG_EF89, 4'hF};
      vecs[5] = '{16'h7600, 4'b0010, {8'hF8, 8'h82, 8'h40, 8'hC0}, 4'hF};

      clear  = 1'b0;
      blank  = 1'b0;
      digits = 16'h1234;
      dp     = 4'h0;
      repeat (3) @(negedge mclk);
      check("reset_an", {4'h0, an}, 8'h0F);
      check("reset_seg", seg, 8'hFF);

      // Release clear away from the clock edge; frames start aligned to d0.
      clear = 1'b1;
      pos   = 0;
      for (int v = 0; v < 6; v++) begin
         digits = vecs[v].digits;
         dp     = vecs[v].dp;
         for (int k = 0; k < 4 * RD; k++) step(vecs[v].segs, vecs[v].lit);
      end

      // Snapshot: change digits when cnt reads 4 in the d0 slot.
      digits = 16'h1234;
      dp     = 4'h0;
      for (int k = 0; k < 4; k++) step(SEG_1234, 4'hF);
      digits = 16'h5678;
      for (int k = 0; k < 4; k++) step(SEG_1234, 4'hF);
      for (int k = 0; k < 3 * RD; k++) step(SEG_5678, 4'hF);

      // Blank: one-cycle blank at cnt=5 of d0, then a blank held across the wrap.
      digits = 16'h1234;
      for (int k = 0; k < 5; k++) step(SEG_1234, 4'hF);
      blank = 1'b1; exp_blank = 1'b1;
      step(SEG_1234, 4'hF);
      blank = 1'b0; exp_blank = 1'b0;
      step(SEG_1234, 4'hF);
      blank = 1'b1; exp_blank = 1'b1;
      for (int k = 0; k < 5; k++) step(SEG_1234, 4'hF);
      blank = 1'b0; exp_blank = 1'b0;
      for (int k = 0; k < 4 * RD - 12; k++) step(SEG_1234, 4'hF);

      // Clear at cnt=5 of the d1 slot: dark immediately, scan restarts at d0.
      for (int k = 0; k < RD + 5; k++) step(SEG_1234, 4'hF);
      clear = 1'b0;
      #1;
      check("clear_an", {4'h0, an}, 8'h0F);
      check("clear_seg", seg, 8'hFF);
      repeat (2) @(negedge mclk);
      check("clear_hold_an", {4'h0, an}, 8'h0F);
      digits = 16'hEF89;
      dp     = 4'b0001;
      clear  = 1'b1;
      pos    = 0;
      for (int k = 0; k < 4 * RD; k++) step(SEG_EF89, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
